// File: rtl/bsg_link_upstream_sched_pkg.sv
// bsg_link_sched_pkg: shared defaults, credit/index types and output-stage state enum
package bsg_link_sched_pkg;
  localparam int NUM_REQ_D = 4;
  localparam int WIDTH_D = 64;
  localparam int CREDITS_D = 16;
  localparam int TOKEN_DECIM_D = 4;
  typedef logic [$clog2(CREDITS_D+TOKEN_DECIM_D+1)-1:0] credit_t;
  typedef logic [$clog2(NUM_REQ_D)-1:0] rr_idx_t;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/bsg_link_upstream_sched_if.sv
// bsg_link_upstream_sched_if: requester bus, link port, token and status; slave=scheduler, master=environment
interface bsg_link_upstream_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 64,
  parameter int CREDITS = 16
);
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic link_valid_o;
  logic [WIDTH-1:0] link_data_o;
  logic link_ready_i;
  logic token_i;
  logic [$clog2(NUM_REQ)-1:0] grant_id_o;
  logic [$clog2(CREDITS+1)-1:0] credit_cnt_o;
  logic credit_ovf_o;
  modport slave (
    input req_valid_i, req_data_i, link_ready_i, token_i,
    output req_ready_o, link_valid_o, link_data_o, grant_id_o, credit_cnt_o, credit_ovf_o
  );
  modport master (
    output req_valid_i, req_data_i, link_ready_i, token_i,
    input req_ready_o, link_valid_o, link_data_o, grant_id_o, credit_cnt_o, credit_ovf_o
  );
endinterface

// File: rtl/bsg_link_rr_arb.sv
// bsg_link_rr_arb: combinational round-robin pick (i_valid, i_last -> o_grant one-hot, o_idx)
module bsg_link_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_valid,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int IW = $clog2(N);
  int w;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    w = 0;
    for (int k = N; k >= 1; k--) begin
      w = int'(i_last) + k;
      w = (w >= N) ? w - N : w;
      if (i_valid[w]) begin
        o_grant = '0;
        o_grant[w] = 1'b1;
        o_idx = w[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/bsg_link_upstream_sched.sv
// bsg_link_upstream_sched: credit-aware RR scheduler (clk, rst, bus: requesters -> registered link stage, token credits)
module bsg_link_upstream_sched
  import bsg_link_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int CREDITS = CREDITS_D,
  parameter int TOKEN_DECIM = TOKEN_DECIM_D
) (
  input logic clk,
  input logic rst,
  bsg_link_upstream_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS+TOKEN_DECIM+1);
  localparam int OW = $clog2(CREDITS+1);
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_last, r_gid, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0] r_credit, w_sum;
  logic r_ovf, w_load;
  bsg_link_rr_arb #(.N(NUM_REQ)) u_arb (
    .i_valid(bus.req_valid_i),
    .i_last(r_last),
    .o_grant(w_grant),
    .o_idx(w_idx)
  );
  always_comb begin
    w_load = (r_state == EMPTY || bus.link_ready_i) && (|r_credit) && (|bus.req_valid_i) && !rst;
    w_state_nx = w_load ? FULL : (r_state == FULL && bus.link_ready_i) ? EMPTY : r_state;
    w_sum = r_credit - CW'(w_load) + (bus.token_i ? CW'(TOKEN_DECIM) : CW'(0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data <= '0;
      r_gid <= '0;
      r_last <= IW'(NUM_REQ-1);
      r_credit <= CW'(CREDITS);
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_credit <= (w_sum > CW'(CREDITS)) ? CW'(CREDITS) : w_sum;
      r_ovf <= r_ovf | (w_sum > CW'(CREDITS));
      if (w_load) begin
        r_data <= bus.req_data_i[int'(w_idx)*WIDTH +: WIDTH];
        r_gid <= w_idx;
        r_last <= w_idx;
      end
    end
  end
  assign bus.req_ready_o = w_load ? w_grant : '0;
  assign bus.link_valid_o = (r_state == FULL);
  assign bus.link_data_o = r_data;
  assign bus.grant_id_o = r_gid;
  assign bus.credit_cnt_o = r_credit[OW-1:0];
  assign bus.credit_ovf_o = r_ovf;
endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
// tb_bsg_link_upstream_sched: table-driven and directed checks of the credit RR scheduler
module tb_bsg_link_upstream_sched;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  int sent;
  always #5 clk = ~clk;
  bsg_link_upstream_sched_if #(.NUM_REQ(4), .WIDTH(64), .CREDITS(16)) bus ();
  bsg_link_upstream_sched #(.NUM_REQ(4), .WIDTH(64), .CREDITS(16), .TOKEN_DECIM(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [3:0] v;
    logic lr;
    logic [3:0] rdy;
    logic lv;
    logic [63:0] d;
    logic [1:0] g;
    logic [4:0] c;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%0h exp=%0h", n, a, e);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.token_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.req_ready_o != 4'b0) sent++;
      @(negedge clk);
    end
  endtask
  initial begin
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 64'h0,  2'd0, 5'd16};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 64'hA0, 2'd0, 5'd15};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 64'hA1, 2'd1, 5'd14};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 64'hA2, 2'd2, 5'd13};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 64'hA3, 2'd3, 5'd12};
    tbl[5]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 64'hA0, 2'd0, 5'd11};
    tbl[6]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 64'hA0, 2'd0, 5'd11};
    tbl[7]  = '{4'hF, 1'b0, 4'b0010, 1'b0, 64'hA0, 2'd0, 5'd11};
    tbl[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[9]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[10] = '{4'hF, 1'b0, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[11] = '{4'hF, 1'b0, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[12] = '{4'hF, 1'b0, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[13] = '{4'h0, 1'b1, 4'b0000, 1'b1, 64'hA1, 2'd1, 5'd10};
    tbl[14] = '{4'h0, 1'b0, 4'b0000, 1'b0, 64'hA1, 2'd1, 5'd10};
    bus.req_data_i = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    bus.req_valid_i = 4'hF;
    bus.link_ready_i = 1'b1;
    bus.token_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 64'(bus.req_ready_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.req_valid_i = tbl[i].v;
      bus.link_ready_i = tbl[i].lr;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_valid", i), 64'(bus.link_valid_o), 64'(tbl[i].lv));
      chk($sformatf("v%0d_data", i), bus.link_data_o, tbl[i].d);
      chk($sformatf("v%0d_gid", i), 64'(bus.grant_id_o), 64'(tbl[i].g));
      chk($sformatf("v%0d_credit", i), 64'(bus.credit_cnt_o), 64'(tbl[i].c));
      chk($sformatf("v%0d_ovf", i), 64'(bus.credit_ovf_o), 64'h0);
      @(negedge clk);
    end
    do_reset();
    bus.req_valid_i = 4'b0100;
    bus.link_ready_i = 1'b1;
    sent = 0;
    run(20);
    chk("exhaust_sent", 64'(sent), 64'd16);
    #1;
    chk("exhaust_credit", 64'(bus.credit_cnt_o), 64'd0);
    chk("exhaust_ready", 64'(bus.req_ready_o), 64'h0);
    chk("exhaust_data", bus.link_data_o, 64'hA2);
    chk("exhaust_gid", 64'(bus.grant_id_o), 64'd2);
    bus.token_i = 1'b1;
    #1;
    chk("token_no_comb", 64'(bus.req_ready_o), 64'h0);
    @(negedge clk);
    bus.token_i = 1'b0;
    sent = 0;
    run(8);
    chk("token_sent", 64'(sent), 64'd4);
    #1;
    chk("token_credit0", 64'(bus.credit_cnt_o), 64'd0);
    chk("token_ovf", 64'(bus.credit_ovf_o), 64'h0);
    @(negedge clk);
    do_reset();
    run(13);
    #1;
    chk("cr3", 64'(bus.credit_cnt_o), 64'd3);
    bus.token_i = 1'b1;
    #1;
    chk("cr3_ready", 64'(bus.req_ready_o), 64'b0100);
    @(negedge clk);
    bus.req_valid_i = 4'b0;
    #1;
    chk("cr3_load_tok", 64'(bus.credit_cnt_o), 64'd6);
    @(negedge clk);
    @(negedge clk);
    bus.token_i = 1'b0;
    #1;
    chk("cr14", 64'(bus.credit_cnt_o), 64'd14);
    chk("cr14_ovf", 64'(bus.credit_ovf_o), 64'h0);
    bus.token_i = 1'b1;
    @(negedge clk);
    bus.token_i = 1'b0;
    #1;
    chk("clamp", 64'(bus.credit_cnt_o), 64'd16);
    chk("ovf_set", 64'(bus.credit_ovf_o), 64'h1);
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    bus.req_valid_i = 4'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ovf_sticky", 64'(bus.credit_ovf_o), 64'h1);
    chk("ovf_credit", 64'(bus.credit_cnt_o), 64'd15);
    @(negedge clk);
    do_reset();
    bus.req_valid_i = 4'hF;
    bus.link_ready_i = 1'b1;
    run(11);
    #1;
    chk("mid_full", 64'(bus.link_valid_o), 64'h1);
    chk("mid_cr5", 64'(bus.credit_cnt_o), 64'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus.req_ready_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_valid", 64'(bus.link_valid_o), 64'h0);
    chk("mid_credit", 64'(bus.credit_cnt_o), 64'd16);
    chk("mid_ovf", 64'(bus.credit_ovf_o), 64'h0);
    chk("mid_first", 64'(bus.req_ready_o), 64'b0001);
    @(negedge clk);
    #1;
    chk("mid_data", bus.link_data_o, 64'hA0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
